// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - shared instruction/data memory port of the multi-cycle controller
interface multicycle_controller_if;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic [2:0] dm_ctrl;
  logic       mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    output dm_ctrl,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    input  dm_ctrl,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle sequencer with memory timeout and trap
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            halt,
  input  logic [31:0]                     instr,
  multicycle_controller_if.master         mem,
  output logic                            ir_write,
  output logic                            mdr_write,
  output logic                            pc_write,
  output logic                            alu_result_write,
  output logic                            ru_write,
  output logic [3:0]                      alu_op,
  output logic [2:0]                      imm_src,
  output logic [1:0]                      alu_a_src,
  output logic                            alu_b_src,
  output logic [1:0]                      ru_data_src,
  output logic [31:0]                     retired,
  output logic                            trap,
  output logic [1:0]                      trap_cause,
  output logic [2:0]                      state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM_RD    = 3'd4,
    S_MEM_WR    = 3'd5,
    S_WRITEBACK = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic [1:0] fault_cause;
  logic       retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_lui, is_auipc, legal;
  logic       mem_phase;
  logic       timeout_hit;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign legal    = is_r | is_i | is_ld | is_st | is_lui | is_auipc;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // The wait counter only matters while a memory request is outstanding.
  assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout_hit = mem_phase && !mem.mem_ready && (wait_cnt == TMO_LAST);

  assign trap  = (state_q == S_TRAP);
  assign state = state_q;

  // Next-state selection and per-state datapath strobes.
  always_comb begin
    state_next           = state_q;
    fault_cause          = 2'b00;
    retire               = 1'b0;
    mem.mem_req          = 1'b0;
    mem.mem_we           = 1'b0;
    mem.mem_addr_sel     = 1'b0;
    mem.dm_ctrl          = 3'b000;
    ir_write             = 1'b0;
    mdr_write            = 1'b0;
    pc_write             = 1'b0;
    alu_result_write     = 1'b0;
    ru_write             = 1'b0;
    alu_op               = 4'b0000;
    imm_src              = 3'b000;
    alu_a_src            = 2'b00;
    alu_b_src            = 1'b0;
    ru_data_src          = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (!halt) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          fault_cause = 2'b10;
          state_next  = S_TRAP;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXECUTE;
        end else begin
          fault_cause = 2'b01;
          state_next  = S_TRAP;
        end
      end
      S_EXECUTE: begin
        alu_result_write = 1'b1;
        state_next       = S_WRITEBACK;
        if (is_r) begin
          alu_op = {instr[30], funct3};
        end else if (is_i) begin
          // Bit 30 only selects SRA vs SRL for shifts; elsewhere it is immediate data.
          alu_op    = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? {instr[30], funct3} : {1'b0, funct3};
          alu_b_src = 1'b1;
        end else if (is_ld) begin
          alu_b_src  = 1'b1;
          state_next = S_MEM_RD;
        end else if (is_st) begin
          imm_src    = 3'b001;
          alu_b_src  = 1'b1;
          state_next = S_MEM_WR;
        end else if (is_auipc) begin
          imm_src   = 3'b100;
          alu_a_src = 2'b01;
          alu_b_src = 1'b1;
        end else if (is_lui) begin
          imm_src = 3'b100;
        end
      end
      S_MEM_RD: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.dm_ctrl      = funct3;
        if (mem.mem_ready) begin
          mdr_write  = 1'b1;
          state_next = S_WRITEBACK;
        end else if (timeout_hit) begin
          fault_cause = 2'b10;
          state_next  = S_TRAP;
        end
      end
      S_MEM_WR: begin
        mem.mem_req      = 1'b1;
        mem.mem_we       = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.dm_ctrl      = funct3;
        imm_src          = 3'b001;
        if (mem.mem_ready) begin
          retire     = 1'b1;
          state_next = halt ? S_IDLE : S_FETCH;
        end else if (timeout_hit) begin
          fault_cause = 2'b10;
          state_next  = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        ru_write    = 1'b1;
        imm_src     = (is_lui || is_auipc) ? 3'b100 : 3'b000;
        ru_data_src = is_ld ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
        retire      = 1'b1;
        state_next  = halt ? S_IDLE : S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_next;
  end

  // Memory wait counter: restarts on every state change, counts stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wait_cnt <= 8'd0;
    else if (state_next != state_q)              wait_cnt <= 8'd0;
    else if (mem_phase && !mem.mem_ready)        wait_cnt <= wait_cnt + 8'd1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= 32'd0;
    else if (retire) retired <= retired + 32'd1;
  end

  // Trap cause is captured once on entry to TRAP and held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          trap_cause <= 2'b00;
    else if ((state_q != S_TRAP) && (state_next == S_TRAP)) trap_cause <= fault_cause;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I core variant with one shared instruction/data memory port.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath strobes and mux selects.
- Uses the same select encodings as the single-cycle decode.
- Supported opcodes: R-type, I-ALU, load, store, LUI, AUIPC. Any other opcode traps.

Parameters:
MEM_TIMEOUT, 16, number of cycles a memory request may wait for mem_ready before trapping (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
halt  in  1  hold in IDLE before the next fetch
instr  in  32  instruction register contents, valid from DECODE onward
mem_ready  in  1  memory completes the transfer this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write
mem_addr_sel  out  1  0 = PC, 1 = ALU result register
ir_write  out  1  latch read data into IR
mdr_write  out  1  latch read data into the memory data register
pc_write  out  1  PC <= PC+4
alu_result_write  out  1  latch the ALU output register
ru_write  out  1  register file write
alu_op  out  4  ALU operation
imm_src  out  3  000 I, 001 S, 100 U
alu_a_src  out  2  00 rs1, 01 PC
alu_b_src  out  1  0 rs2, 1 immediate
dm_ctrl  out  3  load/store width, equal to funct3
ru_data_src  out  2  00 ALU result, 01 MDR, 11 immediate
retired  out  32  count of retired instructions, wraps
trap  out  1  controller has stopped on a fault
trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
state  out  3  debug: current state encoding

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM_RD=4, MEM_WR=5, WRITEBACK=6, TRAP=7.
- Reset (asynchronous, any time, including mid-transfer):
  - state = IDLE; retired = 0; trap = 0; trap_cause = 00; timeout counter = 0.
  - All strobes and selects = 0.
- Default value of every output in every state not listed below is 0. Outputs never take the value x.
- IDLE: go to FETCH when halt=0; otherwise stay in IDLE.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ready: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
- DECODE: classify instr[6:0].
  - Unsupported opcode: go to TRAP with cause 01.
  - Otherwise go to EXECUTE.
- EXECUTE: alu_result_write=1, with ALU selects per class:
  - R-type: alu_op={instr[30], funct3}; b=rs2.
  - I-ALU: alu_op={instr[30], funct3} when funct3 is 001 or 101, else {0, funct3}; imm_src=000; b=imm.
  - Load: alu_op=0000; imm_src=000; b=imm.
  - Store: alu_op=0000; imm_src=001; b=imm.
  - AUIPC: alu_op=0000; imm_src=100; a=PC; b=imm.
  - LUI: imm_src=100; ALU result unused.
  - Next state: load goes to MEM_RD, store goes to MEM_WR, all other classes go to WRITEBACK.
- MEM_RD:
  - mem_req=1, mem_addr_sel=1, dm_ctrl=funct3.
  - On mem_ready: mdr_write=1, then go to WRITEBACK.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_addr_sel=1, dm_ctrl=funct3, imm_src=001.
  - On mem_ready: retire the instruction, then go to IDLE if halt=1, else FETCH.
- WRITEBACK:
  - ru_write=1; imm_src held per class.
  - ru_data_src: 01 for load, 11 for LUI, 00 otherwise.
  - Retire the instruction, then go to IDLE if halt=1, else FETCH.
- Retire means retired increments by 1. It wraps from 0xFFFFFFFF to 0.
- Memory handshake:
  - A transfer completes in the cycle where mem_req and mem_ready are both 1.
  - mem_req and the address select stay stable until that cycle.
  - mem_ready is ignored when mem_req=0.
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle there without mem_ready.
  - When the counter reaches MEM_TIMEOUT-1 and mem_ready is still 0, the next state is TRAP with cause 10.
  - mem_ready arriving on that same cycle wins: the transfer completes normally.
- halt:
  - Sampled only in IDLE and at retire.
  - halt=1 in any other state does not abort an instruction in flight.
- TRAP:
  - trap=1; trap_cause holds its value; all strobes are 0.
  - Stays in TRAP until reset; halt has no effect.
- Latency with zero-wait memory:
  - R-type, I-ALU, LUI and AUIPC take 4 cycles.
  - Store takes 4 cycles.
  - Load takes 5 cycles.

Test Plan:
- Reset with halt=0, memory with zero wait, instr=0x00500093 (addi x1,x0,5):
  - state sequence 0,1,2,3,6,1.
  - ru_write pulses once with alu_op=0000, alu_b_src=1.
  - retired=1 after the WRITEBACK edge.
- Load 0x0000A103 (lw x2,0(x1)) with mem_ready delayed 3 cycles in MEM_RD:
  - mem_req is held 4 cycles with mem_addr_sel=1 and dm_ctrl=010.
  - mdr_write pulses once, then WRITEBACK drives ru_data_src=01.
- instr=0x40000033 (sub), then 0x4010D093 (srai):
  - alu_op=1000 for sub, 1101 for srai.
  - instr=0x40004093 (xori) gives alu_op=0100, with bit 30 ignored.
- Opcode 0x6F (jal) in DECODE:
  - next state is TRAP with trap=1, trap_cause=01.
  - mem_req stays 0 forever; retired is unchanged.
- mem_ready held at 0 in FETCH with MEM_TIMEOUT=16:
  - TRAP is entered with cause 10 exactly 16 cycles after FETCH entry.
  - A repeat run with mem_ready in cycle 16 completes the fetch instead.
- Reset asserted mid-MEM_WR, and halt=1 asserted at retire:
  - Reset immediately forces all outputs to 0 and state to IDLE.
  - After release with halt=1, the controller stays in IDLE with no mem_req.
  - Deasserting halt starts FETCH the next cycle.
